// File: rtl/comparator.sv
// Registered magnitude comparator: eq/lt/gt flags for operands a and b.
// Unsigned or two's-complement compare selected by SIGNED; MSB-first
// priority scan, so there is no subtraction and no overflow path.
// Optional macro COMPARATOR_INPUT_REG_EN adds an input register stage
// (2-cycle latency); without it the latency is 1 cycle.
module comparator #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             lt_c;
  logic             gt_c;
  logic             decided;
  logic             eq_d, lt_d, gt_d;
  logic             eq_q, lt_q, gt_q;

`ifdef COMPARATOR_INPUT_REG_EN
  logic [WIDTH-1:0] a_d, b_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             vld_d, vld_q;

  // Next state of the input stage; vld marks that a_q/b_q hold real operands
  always_comb begin
    a_d   = a;
    b_d   = b;
    vld_d = 1'b1;
  end

  // Input operand registers, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = a;
  assign op_b = b;
`endif

  // MSB-first scan: the first differing bit decides; in signed mode the sign bit inverts the sense
  always_comb begin
    lt_c    = 1'b0;
    gt_c    = 1'b0;
    decided = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!decided && (op_a[i] != op_b[i])) begin
        decided = 1'b1;
        if ((SIGNED != 0) && (i == int'(WIDTH) - 1)) begin
          lt_c = op_a[i];
          gt_c = op_b[i];
        end else begin
          lt_c = op_b[i];
          gt_c = op_a[i];
        end
      end
    end
  end

  // Next flag values; held at 0 until the input stage carries sampled operands
  always_comb begin
    eq_d = ~lt_c & ~gt_c;
    lt_d = lt_c;
    gt_d = gt_c;
`ifdef COMPARATOR_INPUT_REG_EN
    if (!vld_q) begin
      eq_d = 1'b0;
      lt_d = 1'b0;
      gt_d = 1'b0;
    end
`endif
  end

  // Output flag registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_q <= 1'b0;
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      eq_q <= eq_d;
      lt_q <= lt_d;
      gt_q <= gt_d;
    end
  end

  assign eq = eq_q;
  assign lt = lt_q;
  assign gt = gt_q;

endmodule

// File: tb/tb_comparator.sv
// Bench for comparator: directed cases plus randomized compare against an
// integer-arithmetic reference, for both SIGNED settings side by side.
module tb_comparator;

  localparam int unsigned W = 4;
`ifdef COMPARATOR_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         eq_u, lt_u, gt_u;
  logic         eq_s, lt_s, gt_s;
  logic [2:0]   f_u, f_s;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  assign f_u = {eq_u, lt_u, gt_u};
  assign f_s = {eq_s, lt_s, gt_s};

  comparator #(.WIDTH(W), .SIGNED(0)) u_cmp_u (
    .clk(clk), .rst(rst), .a(a), .b(b), .eq(eq_u), .lt(lt_u), .gt(gt_u)
  );

  comparator #(.WIDTH(W), .SIGNED(1)) u_cmp_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .eq(eq_s), .lt(lt_s), .gt(gt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: turn operands into plain integers and compare them; result is {eq,lt,gt}
  function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input bit sgn);
    int xv;
    int yv;
    xv = int'(x);
    yv = int'(y);
    if (sgn && x[W-1]) xv = xv - (1 << W);
    if (sgn && y[W-1]) yv = yv - (1 << W);
    return {xv == yv, xv < yv, xv > yv};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Apply operands, wait out the latency, check both instances against constants
  task automatic apply_chk(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2:0] eu, input logic [2:0] es);
    a = x;
    b = y;
    repeat (LAT) tick();
    chk({tag, "_u"}, 32'(f_u), 32'(eu));
    chk({tag, "_s"}, 32'(f_s), 32'(es));
  endtask

  // From just after reset release: flags stay 0 until the latency elapses
  task automatic post_reset_chk(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [2:0] eu, input logic [2:0] es);
    a = x;
    b = y;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) begin
        chk({tag, "_early_u"}, 32'(f_u), 32'd0);
        chk({tag, "_early_s"}, 32'(f_s), 32'd0);
      end
    end
    chk({tag, "_u"}, 32'(f_u), 32'(eu));
    chk({tag, "_s"}, 32'(f_s), 32'(es));
  endtask

  logic [2:0] q_u[$];
  logic [2:0] q_s[$];

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    #1;
    chk("rst_async_u", 32'(f_u), 32'd0);
    chk("rst_async_s", 32'(f_s), 32'd0);
    do_reset();

    // First operands after reset
    post_reset_chk("first_5_3", 4'd5, 4'd3, 3'b001, 3'b001);

    // 2 vs 8: unsigned lt; signed 8 is -8 so gt
    apply_chk("r025", 4'b0010, 4'b1000, 3'b010, 3'b001);
    tick();
    chk("r025_hold_u", 32'(f_u), 32'(3'b010));
    chk("r025_hold_s", 32'(f_s), 32'(3'b001));

    apply_chk("r026_5_3", 4'b0101, 4'b0011, 3'b001, 3'b001);
    apply_chk("r026_15_5", 4'b1111, 4'b0101, 3'b001, 3'b010);

    // Equal operands including the extremes
    apply_chk("eq_4", 4'b0100, 4'b0100, 3'b100, 3'b100);
    apply_chk("eq_0", 4'b0000, 4'b0000, 3'b100, 3'b100);
    apply_chk("eq_f", 4'b1111, 4'b1111, 3'b100, 3'b100);
    apply_chk("min_max", 4'b0111, 4'b1000, 3'b010, 3'b001);

    // Operands change between edges; flags must hold until the next edge
    apply_chk("pre_mid", 4'b1111, 4'b0101, 3'b001, 3'b010);
    a = 4'd0;
    b = 4'd15;
    #3;
    chk("between_edges_u", 32'(f_u), 32'(3'b001));
    chk("between_edges_s", 32'(f_s), 32'(3'b010));

    // Mid-cycle reset while gt is high: immediate clear, nothing stale after release
    apply_chk("pre_rst", 4'b0101, 4'b0011, 3'b001, 3'b001);
    rst = 1'b1;
    #1;
    chk("mid_rst_u", 32'(f_u), 32'd0);
    chk("mid_rst_s", 32'(f_s), 32'd0);
    #2;
    a   = 4'd2;
    b   = 4'd8;
    rst = 1'b0;
    chk("rel_rst_u", 32'(f_u), 32'd0);
    chk("rel_rst_s", 32'(f_s), 32'd0);
    post_reset_chk("after_rst", 4'd2, 4'd8, 3'b010, 3'b001);

    // Randomized operands every edge, compared against the delayed reference
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      q_u.push_back(ref_flags(a, b, 1'b0));
      q_s.push_back(ref_flags(a, b, 1'b1));
      tick();
      if (q_u.size() >= LAT) begin
        chk("rand_u", 32'(f_u), 32'(q_u.pop_front()));
        chk("rand_s", 32'(f_s), 32'(q_s.pop_front()));
        chk("onehot_u", 32'($countones(f_u)), 32'd1);
        chk("onehot_s", 32'($countones(f_s)), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
- REQ-001: Parameter WIDTH, default 4: operand width in bits, legal range 1..32.
- REQ-002: Parameter SIGNED, default 0: 0 selects unsigned compare; 1 selects two's-complement compare.
- REQ-003: Port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-005: Port a, input, WIDTH bits: first operand.
- REQ-006: Port b, input, WIDTH bits: second operand.
- REQ-007: Port eq, output, 1 bit: registered flag, high when a equals b.
- REQ-008: Port lt, output, 1 bit: registered flag, high when a is less than b.
- REQ-009: Port gt, output, 1 bit: registered flag, high when a is greater than b.

Function
- REQ-010: The block SHALL sample a and b on every rising clk edge. It SHALL drive eq, lt and gt from flip-flops.
- REQ-011: With COMPARATOR_INPUT_REG_EN undefined, the flags SHALL reflect the operands sampled one clk edge earlier, giving 1-cycle latency.
- REQ-012: Outside reset, after the first post-reset edge, exactly one of eq, lt, gt SHALL be high on every cycle.
- REQ-013: With SIGNED=0, the block SHALL compare a and b as unsigned values across the full WIDTH.
- REQ-014: With SIGNED=1, the MSB SHALL be the sign bit. For example, with WIDTH=4, 4'b1111 = -1 is less than 4'b0101 = 5.
- REQ-015: The compare SHALL be an MSB-first bit-serial priority or tree structure with no internal arithmetic overflow. Equal operands at the extreme values (all-zeros, all-ones) SHALL yield eq.
- REQ-016: Operands held constant SHALL keep the flags constant, with no glitch between edges.
- REQ-017: A change of a or b between edges SHALL NOT affect the outputs until the next sampling edge.
- REQ-018: X or Z on the operands is out of scope. The block has no enable; it compares on every edge.

Reset
- REQ-019: While rst is high, eq, lt and gt SHALL be 0 immediately, without waiting for a clk edge. Any internal operand registers SHALL also be cleared to 0.
- REQ-020: After rst deasserts, the first rising clk edge SHALL begin normal sampling. Valid flags SHALL appear after the configured latency.
- REQ-021: Asserting rst mid-operation SHALL discard any in-flight comparison. No stale result SHALL appear after release.

Configuration
- REQ-022: Macro COMPARATOR_INPUT_REG_EN SHALL control an input register stage.
- REQ-023: With COMPARATOR_INPUT_REG_EN defined, a and b SHALL first be registered, then compared and registered again, giving 2-cycle latency. The flags SHALL stay 0 for the first 2 edges after reset.
- REQ-024: With COMPARATOR_INPUT_REG_EN undefined, the block SHALL have no input stage and 1-cycle latency. The interface SHALL be identical in both builds.

Verification (WIDTH=4, SIGNED=0, macro undefined unless stated)
- REQ-025: a=4'b0010, b=4'b1000, hold 2 edges -> lt=1, eq=0, gt=0.
- REQ-026: a=4'b0101, b=4'b0011 -> gt=1, eq=0, lt=0 one edge after apply. a=4'b1111, b=4'b0101 -> gt=1. The same 1111/0101 case with SIGNED=1 -> lt=1.
- REQ-027: a=b=4'b0100, then a=b=4'b0000, then a=b=4'b1111 -> eq=1 each cycle, lt=0, gt=0.
- REQ-028: rst pulse between edges while gt=1 -> all flags 0 at once. After release, first edge with a=2, b=8 -> lt=1.
- REQ-029: With COMPARATOR_INPUT_REG_EN defined, a=5, b=3 applied right after reset -> flags 0 after edge 1, gt=1 after edge 2.
- REQ-030: Random a, b on every edge, 1000 cycles, both SIGNED settings -> flags match a reference model delayed by the latency, exactly one flag high.
